// File: rtl/tx_link_ctrl_if.sv
// Upstream word handshake between a word source and the link controller.
// The source (master) offers a word with reqValid/reqData/reqK.
// The controller (slave) answers with a combinational reqReady.
interface tx_link_ctrl_if;
   logic        reqValid;
   logic [31:0] reqData;
   logic        reqK;
   logic        reqReady;

   modport master (
      output reqValid,
      output reqData,
      output reqK,
      input  reqReady
   );

   modport slave (
      input  reqValid,
      input  reqData,
      input  reqK,
      output reqReady
   );
endinterface

// File: rtl/tx_link_ctrl.sv
// Transmit link controller.
// Brings the link up: electrical idle, then wake, then COM training, then active.
// While active it paces words at one per word period and inserts SKP words periodically.
// A stop request sends EIOS, holds it for one word period, and returns to electrical idle.
module tx_link_ctrl #(
   parameter int TS_COUNT     = 4,
   parameter int IDLE_MIN     = 8,
   parameter int SKP_INTERVAL = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enb,
   input  logic          start,
   input  logic          stop,
   input  logic [1:0]    dataS,
   tx_link_ctrl_if.slave req,
   output logic [31:0]   txData,
   output logic          txK,
   output logic          txElecIdle,
   output logic          txLoad,
   output logic          linkUp,
   output logic [2:0]    state
);

   // cnt doubles as the wake timer, so it must cover both the longest word and IDLE_MIN.
   localparam int CNT_MAX = (IDLE_MIN > 40) ? IDLE_MIN : 40;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int TS_W    = $clog2(TS_COUNT + 1);

   localparam logic [7:0] SYM_COM  = 8'hBC;
   localparam logic [7:0] SYM_EIOS = 8'h7C;
   localparam logic [7:0] SYM_SKP  = 8'h1C;
   localparam logic [7:0] SYM_IDLE = 8'h00;

   typedef enum logic [2:0] {
      ST_ELEC_IDLE = 3'd0,
      ST_WAKE      = 3'd1,
      ST_TRAIN     = 3'd2,
      ST_ACTIVE    = 3'd3,
      ST_STOPPING  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         width_q, width_d;
   logic [TS_W-1:0]    ts_cnt_q, ts_cnt_d;
   logic [9:0]         word_cnt_q, word_cnt_d;
   logic               stop_flag_q, stop_flag_d;
   logic [31:0]        tx_data_q, tx_data_d;
   logic               tx_k_q, tx_k_d;

   logic [CNT_W-1:0]   last_cnt;
   logic [CNT_W-1:0]   cnt_wrap;
   logic               skp_due;
   logic               load_word;
   logic [31:0]        word_sel;
   logic               word_k;

   // Replicate a symbol byte across the lanes of the latched width; upper lanes stay 0.
   function automatic logic [31:0] lanes(input logic [7:0] b, input logic [1:0] w);
      case (w)
         2'b01:   lanes = {16'h0000, b, b};
         2'b10:   lanes = {b, b, b, b};
         default: lanes = {24'h000000, b};
      endcase
   endfunction

   // Keep only the low bytes of an upstream word that fit the latched width.
   function automatic logic [31:0] mask_data(input logic [31:0] d, input logic [1:0] w);
      case (w)
         2'b01:   mask_data = {16'h0000, d[15:0]};
         2'b10:   mask_data = d;
         default: mask_data = {24'h000000, d[7:0]};
      endcase
   endfunction

   // Last cnt value of a word period: 10, 20 or 40 cycles per word.
   always_comb begin
      case (width_q)
         2'b01:   last_cnt = CNT_W'(19);
         2'b10:   last_cnt = CNT_W'(39);
         default: last_cnt = CNT_W'(9);
      endcase
   end

   assign cnt_wrap = (cnt_q == last_cnt) ? '0 : cnt_q + CNT_W'(1);
   assign skp_due  = (word_cnt_q == 10'(SKP_INTERVAL));

   // Next-state, counters and word selection; nothing moves while enb is low.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      width_d     = width_q;
      ts_cnt_d    = ts_cnt_q;
      word_cnt_d  = word_cnt_q;
      stop_flag_d = stop_flag_q;
      tx_data_d   = tx_data_q;
      tx_k_d      = tx_k_q;
      load_word   = 1'b0;
      word_sel    = '0;
      word_k      = 1'b0;

      if (enb) begin
         case (state_q)
            ST_ELEC_IDLE: begin
               // stop is ignored here, so start always wins a same-cycle request.
               if (start) begin
                  state_d     = ST_WAKE;
                  width_d     = dataS;
                  cnt_d       = '0;
                  ts_cnt_d    = '0;
                  word_cnt_d  = '0;
                  stop_flag_d = 1'b0;
               end
            end

            ST_WAKE: begin
               if (stop) stop_flag_d = 1'b1;
               if (cnt_q == CNT_W'(IDLE_MIN - 1)) begin
                  state_d = ST_TRAIN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            ST_TRAIN: begin
               if (stop) stop_flag_d = 1'b1;
               cnt_d = cnt_wrap;
               if (cnt_q == '0) begin
                  load_word = 1'b1;
                  word_sel  = lanes(SYM_COM, width_q);
                  word_k    = 1'b1;
                  ts_cnt_d  = ts_cnt_q + TS_W'(1);
               end
               // Entering ACTIVE at the wrap makes the boundary after the last COM an ACTIVE one.
               if ((cnt_q == last_cnt) && (ts_cnt_q == TS_W'(TS_COUNT))) begin
                  state_d = ST_ACTIVE;
               end
            end

            ST_ACTIVE: begin
               if (stop) stop_flag_d = 1'b1;
               cnt_d = cnt_wrap;
               if (cnt_q == '0) begin
                  load_word = 1'b1;
                  if (stop_flag_q) begin
                     word_sel = lanes(SYM_EIOS, width_q);
                     word_k   = 1'b1;
                     state_d  = ST_STOPPING;
                  end else if (skp_due) begin
                     word_sel   = lanes(SYM_SKP, width_q);
                     word_k     = 1'b1;
                     word_cnt_d = '0;
                  end else if (req.reqValid) begin
                     word_sel   = mask_data(req.reqData, width_q);
                     word_k     = req.reqK;
                     word_cnt_d = word_cnt_q + 10'd1;
                  end else begin
                     word_sel   = lanes(SYM_IDLE, width_q);
                     word_k     = 1'b0;
                     word_cnt_d = word_cnt_q + 10'd1;
                  end
               end
            end

            ST_STOPPING: begin
               // EIOS stays on the wire for the remainder of its word period.
               if (cnt_q == last_cnt) begin
                  state_d     = ST_ELEC_IDLE;
                  cnt_d       = '0;
                  ts_cnt_d    = '0;
                  word_cnt_d  = '0;
                  stop_flag_d = 1'b0;
                  tx_data_d   = '0;
                  tx_k_d      = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            default: begin
               state_d = ST_ELEC_IDLE;
               cnt_d   = '0;
            end
         endcase

         if (load_word) begin
            tx_data_d = word_sel;
            tx_k_d    = word_k;
         end
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_ELEC_IDLE;
         cnt_q       <= '0;
         width_q     <= 2'b00;
         ts_cnt_q    <= '0;
         word_cnt_q  <= '0;
         stop_flag_q <= 1'b0;
         tx_data_q   <= '0;
         tx_k_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         width_q     <= width_d;
         ts_cnt_q    <= ts_cnt_d;
         word_cnt_q  <= word_cnt_d;
         stop_flag_q <= stop_flag_d;
         tx_data_q   <= tx_data_d;
         tx_k_q      <= tx_k_d;
      end
   end

   // Outputs: the new word is visible during its boundary cycle together with txLoad.
   always_comb begin
      txLoad       = load_word & rst;
      txData       = txLoad ? word_sel : tx_data_q;
      txK          = txLoad ? word_k : tx_k_q;
      txElecIdle   = (state_q == ST_ELEC_IDLE);
      linkUp       = (state_q == ST_ACTIVE);
      state        = state_q;
      req.reqReady = rst & enb & (state_q == ST_ACTIVE) & (cnt_q == '0)
                     & ~skp_due & ~stop_flag_q;
   end

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Directed bench for tx_link_ctrl: the stimulus pushes expected words into a queue,
// and a negedge monitor pops one entry per txLoad and checks word, K, ready, linkUp and spacing.
module tb_tx_link_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        enb;
   logic        start;
   logic        stop;
   logic [1:0]  dataS;
   logic [31:0] txData;
   logic        txK;
   logic        txElecIdle;
   logic        txLoad;
   logic        linkUp;
   logic [2:0]  state;

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   int unsigned last_load = 0;

   typedef struct {
      logic [31:0] data;
      logic        k;
      logic        rdy;
      logic        up;
      int          gap;
   } exp_t;
   exp_t exp_q[$];

   tx_link_ctrl_if bus();

   tx_link_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .enb        (enb),
      .start      (start),
      .stop       (stop),
      .dataS      (dataS),
      .req        (bus.slave),
      .txData     (txData),
      .txK        (txK),
      .txElecIdle (txElecIdle),
      .txLoad     (txLoad),
      .linkUp     (linkUp),
      .state      (state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic k, input logic r, input logic u, input int g);
      exp_t e;
      e.data = d;
      e.k    = k;
      e.rdy  = r;
      e.up   = u;
      e.gap  = g;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: one scoreboard entry per txLoad, sampled mid-cycle.
   always @(negedge clk) begin
      if (txLoad === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_load: got txData=%h at cycle %0d, required no load", txData, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("tx_data", txData, e.data);
            check("tx_k", 32'(txK), 32'(e.k));
            check("req_ready", 32'(bus.reqReady), 32'(e.rdy));
            check("link_up", 32'(linkUp), 32'(e.up));
            if (e.gap != 0) check("word_gap", 32'(cyc - last_load), 32'(e.gap));
            $display("word %h k=%0d at cycle %0d", txData, txK, cyc);
         end
         last_load = cyc;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, 32'(state), 32'd0);
      check({tag, "_elec_idle"}, 32'(txElecIdle), 32'd1);
      check({tag, "_tx_data"}, txData, 32'd0);
      check({tag, "_tx_k"}, 32'(txK), 32'd0);
      check({tag, "_tx_load"}, 32'(txLoad), 32'd0);
      check({tag, "_link_up"}, 32'(linkUp), 32'd0);
      check({tag, "_req_ready"}, 32'(bus.reqReady), 32'd0);
   endtask

   initial begin
      rst          = 1'b0;
      enb          = 1'b1;
      start        = 1'b0;
      stop         = 1'b0;
      dataS        = 2'b00;
      bus.reqValid = 1'b0;
      bus.reqData  = 32'h0;
      bus.reqK     = 1'b0;

      // Reset state.
      tick(3);
      check_reset_outputs("reset");
      rst = 1'b1;
      tick(1);
      check("idle_hold_state", 32'(state), 32'd0);

      // 8-bit bring-up; a stop during TRAIN turns the first ACTIVE word into EIOS.
      push(32'h000000BC, 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 3; i++) push(32'h000000BC, 1'b1, 1'b0, 1'b0, 10);
      push(32'h0000007C, 1'b1, 1'b0, 1'b1, 10);
      dataS = 2'b00;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check("a_wake_state", 32'(state), 32'd1);
      check("a_wake_elec_idle", 32'(txElecIdle), 32'd0);
      tick(7);
      check("a_wake_no_load", 32'(txLoad), 32'd0);
      check("a_wake_still", 32'(state), 32'd1);
      tick(1);
      check("a_first_load", 32'(txLoad), 32'd1);
      check("a_train_state", 32'(state), 32'd2);
      tick(15);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      tick(33);
      check("a_stopping_state", 32'(state), 32'd4);
      check("a_stopping_eios_held", txData, 32'h0000007C);
      tick(1);
      check("a_back_idle_state", 32'(state), 32'd0);
      check("a_back_idle_elec", 32'(txElecIdle), 32'd1);
      check("a_back_idle_data", txData, 32'd0);

      // 16-bit: start and stop together (start wins), dataS changed after bring-up,
      // idle words, one masked data word, then a stop mid-word in ACTIVE.
      push(32'h0000BCBC, 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 3; i++) push(32'h0000BCBC, 1'b1, 1'b0, 1'b0, 20);
      push(32'h00000000, 1'b0, 1'b1, 1'b1, 20);
      push(32'h0000F00D, 1'b0, 1'b1, 1'b1, 20);
      push(32'h00000000, 1'b0, 1'b1, 1'b1, 20);
      push(32'h00007C7C, 1'b1, 1'b0, 1'b1, 20);
      dataS = 2'b01;
      start = 1'b1;
      stop  = 1'b1;
      tick(1);
      start = 1'b0;
      stop  = 1'b0;
      dataS = 2'b10;
      check("b_wake_state", 32'(state), 32'd1);
      tick(8);
      check("b_first_load", 32'(txLoad), 32'd1);
      tick(90);
      bus.reqValid = 1'b1;
      bus.reqData  = 32'hCAFEF00D;
      tick(20);
      bus.reqValid = 1'b0;
      tick(15);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      tick(33);
      check("b_stopping_state", 32'(state), 32'd4);
      tick(1);
      check("b_back_idle_state", 32'(state), 32'd0);
      check("b_back_idle_elec", 32'(txElecIdle), 32'd1);

      // 32-bit with reqValid held: 64 data words, one SKP, a K data word,
      // a 5-cycle enb freeze mid-word, then reset while ACTIVE.
      push(32'hBCBCBCBC, 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 3; i++) push(32'hBCBCBCBC, 1'b1, 1'b0, 1'b0, 40);
      for (int i = 0; i < 64; i++) push(32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 40);
      push(32'h1C1C1C1C, 1'b1, 1'b0, 1'b1, 40);
      push(32'h12345678, 1'b1, 1'b1, 1'b1, 40);
      push(32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 45);
      dataS        = 2'b10;
      bus.reqValid = 1'b1;
      bus.reqData  = 32'hA5A5A5A5;
      bus.reqK     = 1'b0;
      start        = 1'b1;
      tick(1);
      start = 1'b0;
      check("c_elec_idle_no_ready_wake", 32'(state), 32'd1);
      tick(8);
      check("c_first_load", 32'(txLoad), 32'd1);
      tick(2730);
      bus.reqData = 32'h12345678;
      bus.reqK    = 1'b1;
      tick(30);
      check("c_k_word_load", 32'(txLoad), 32'd1);
      tick(38);
      enb = 1'b0;
      #1;
      check("c_freeze_load", 32'(txLoad), 32'd0);
      check("c_freeze_ready", 32'(bus.reqReady), 32'd0);
      check("c_freeze_data", txData, 32'h12345678);
      check("c_freeze_state", 32'(state), 32'd3);
      tick(5);
      enb         = 1'b1;
      bus.reqData = 32'hA5A5A5A5;
      bus.reqK    = 1'b0;
      tick(7);
      rst = 1'b0;
      tick(1);
      check_reset_outputs("active_reset");
      rst          = 1'b1;
      bus.reqValid = 1'b0;
      tick(3);

      // Every queued word must have been seen.
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
